// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
//
// Writer side of the instruction-memory interface used by Simple_Single_CPU.
// Little-endian bytes arrive over a valid/ready handshake. Each group of four
// bytes forms a 32-bit word, and each word is written to the next word address.
// The CPU stays in reset while the load runs. An all-zero word is the CPU's
// end-of-program marker. It is written like any other word, and then the CPU is
// released. If DEPTH non-zero words arrive without a terminator, the loader
// parks in an error state.
//
// Optional feature (compile-time macro LOADER_CHECKSUM_EN):
//   defined   -> checksum_o is the mod-2^32 sum of every word written
//   undefined -> checksum_o is tied to zero and no adder exists
//
// Ports
//   clk_i         in   1     clock, rising edge
//   rst_n         in   1     synchronous active-low reset
//   byte_i        in   8     stream byte
//   byte_valid_i  in   1     byte_i valid
//   byte_ready_o  out  1     loader accepts a byte this cycle
//   im_we_o       out  1     instruction-memory write strobe (1 cycle/word)
//   im_addr_o     out  32    byte address of the write (word index << 2)
//   im_wdata_o    out  32    assembled word
//   cpu_rst_n_o   out  1     active-low CPU reset, high only once running
//   done_o        out  1     terminator written, CPU running
//   error_o       out  1     DEPTH words written without a terminator
//   word_count_o  out  AW+1  words written so far, terminator included
//   checksum_o    out  32    running word sum (zero when feature disabled)
// -----------------------------------------------------------------------------
module instr_mem_loader #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk_i,
    input  logic          rst_n,
    input  logic [7:0]    byte_i,
    input  logic          byte_valid_i,
    output logic          byte_ready_o,
    output logic          im_we_o,
    output logic [31:0]   im_addr_o,
    output logic [31:0]   im_wdata_o,
    output logic          cpu_rst_n_o,
    output logic          done_o,
    output logic          error_o,
    output logic [AW:0]   word_count_o,
    output logic [31:0]   checksum_o
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_WRITE = 2'd1,
        ST_RUN   = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] LP_LAST  = (AW+1)'(DEPTH - 1);

    state_t        r_state;
    state_t        w_next_state;

    logic [1:0]    r_byte_idx;
    logic [23:0]   r_shift;
    logic [AW-1:0] r_word_idx;
    logic [AW:0]   r_word_count;
    logic          r_ready;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic          r_cpu_rst_n;
    logic          r_done;
    logic          r_error;

    logic          w_accept;
    logic [31:0]   w_addr;

    // A byte is taken only while the loader is in LOAD and advertising ready.
    assign w_accept = byte_valid_i & r_ready & (r_state == ST_LOAD);
    assign w_addr   = {{(32-AW-2){1'b0}}, r_word_idx, 2'b00};

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. The zero-word test comes before the depth test, so a
    // terminator that is also the last word that fits still reaches RUN.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_LOAD: begin
                if (w_accept && (r_byte_idx == 2'd3)) begin
                    w_next_state = ST_WRITE;
                end else begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_WRITE: begin
                if (r_wdata == 32'd0) begin
                    w_next_state = ST_RUN;
                end else if (r_word_count == LP_LAST) begin
                    w_next_state = ST_ERR;
                end else begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_RUN:  w_next_state = ST_RUN;
            ST_ERR:  w_next_state = ST_ERR;
            default: w_next_state = ST_LOAD;
        endcase
    end

    // Status outputs are registered from the next state. They therefore line up
    // with the state they describe, and ready first rises on the cycle after
    // reset is released.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_ready     <= 1'b0;
            r_we        <= 1'b0;
            r_cpu_rst_n <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_ready     <= (w_next_state == ST_LOAD);
            r_we        <= (w_next_state == ST_WRITE);
            r_cpu_rst_n <= (w_next_state == ST_RUN);
            r_done      <= (w_next_state == ST_RUN);
            r_error     <= (w_next_state == ST_ERR);
        end
    end

    // Byte assembly. The fourth byte goes straight into the write-data register
    // together with the address. Both registers then hold their value until
    // the next word arrives.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_byte_idx <= 2'd0;
            r_shift    <= 24'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
        end else if (w_accept) begin
            case (r_byte_idx)
                2'd0:    r_shift[7:0]   <= byte_i;
                2'd1:    r_shift[15:8]  <= byte_i;
                2'd2:    r_shift[23:16] <= byte_i;
                2'd3: begin
                    r_wdata <= {byte_i, r_shift};
                    r_addr  <= w_addr;
                end
                default: r_shift <= r_shift;
            endcase
            r_byte_idx <= r_byte_idx + 2'd1;
        end else begin
            r_byte_idx <= r_byte_idx;
        end
    end

    // Word index and count advance on the edge that ends each WRITE cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_word_idx   <= {AW{1'b0}};
            r_word_count <= {(AW+1){1'b0}};
        end else if (r_state == ST_WRITE) begin
            r_word_idx <= r_word_idx + AW'(1);
            if (r_word_count != LP_DEPTH) begin
                r_word_count <= r_word_count + (AW+1)'(1);
            end else begin
                r_word_count <= r_word_count;
            end
        end else begin
            r_word_idx   <= r_word_idx;
            r_word_count <= r_word_count;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] r_checksum;

    // Running sum of every written word. The terminator adds zero, and the
    // value stops changing once the loader leaves LOAD/WRITE.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_checksum <= 32'd0;
        end else if (r_state == ST_WRITE) begin
            r_checksum <= r_checksum + r_wdata;
        end else begin
            r_checksum <= r_checksum;
        end
    end

    assign checksum_o = r_checksum;
`else
    assign checksum_o = 32'd0;
`endif

    assign byte_ready_o = r_ready;
    assign im_we_o      = r_we;
    assign im_addr_o    = r_addr;
    assign im_wdata_o   = r_wdata;
    assign cpu_rst_n_o  = r_cpu_rst_n;
    assign done_o       = r_done;
    assign error_o      = r_error;
    assign word_count_o = r_word_count;

endmodule

// File: tb/tb_instr_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_loader
// Directed bench for instr_mem_loader (DEPTH=32, AW=5). Each scenario task
// drives bytes and compares the DUT outputs with hand-computed values. A
// monitor logs every write strobe, so the address and data sequence can be
// checked once the load has finished.
// -----------------------------------------------------------------------------
module tb_instr_mem_loader;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_ready_o;
    logic        im_we_o;
    logic [31:0] im_addr_o;
    logic [31:0] im_wdata_o;
    logic        cpu_rst_n_o;
    logic        done_o;
    logic        error_o;
    logic [5:0]  word_count_o;
    logic [31:0] checksum_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

`ifdef LOADER_CHECKSUM_EN
    localparam bit CK_ON = 1'b1;
`else
    localparam bit CK_ON = 1'b0;
`endif

    always #5 clk_i = ~clk_i;

    instr_mem_loader #(.DEPTH(32), .AW(5)) dut (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .im_we_o      (im_we_o),
        .im_addr_o    (im_addr_o),
        .im_wdata_o   (im_wdata_o),
        .cpu_rst_n_o  (cpu_rst_n_o),
        .done_o       (done_o),
        .error_o      (error_o),
        .word_count_o (word_count_o),
        .checksum_o   (checksum_o)
    );

    // Write monitor, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (im_we_o === 1'b1) begin
            wr_addr.push_back(im_addr_o);
            wr_data.push_back(im_wdata_o);
        end
    end

    function automatic logic [31:0] ck(input logic [31:0] v);
        return CK_ON ? v : 32'd0;
    endfunction

    task automatic do_reset();
        byte_valid_i = 1'b0;
        rst_n = 1'b0;
        @(negedge clk_i);
        rst_n = 1'b1;
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic idle(input int n);
        byte_valid_i = 1'b0;
        repeat (n) @(negedge clk_i);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t = 0;
        byte_i = b;
        byte_valid_i = 1'b1;
        while (byte_ready_o !== 1'b1 && t < 100) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 100) begin
            total++; bad++;
            $display("FAIL send_byte_timeout: ready=%b required 1", byte_ready_o);
            byte_valid_i = 1'b0;
        end else begin
            @(negedge clk_i);
            if (gap) begin
                byte_valid_i = 1'b0;
                @(negedge clk_i);
            end
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        send_byte(w[7:0], gap);
        send_byte(w[15:8], gap);
        send_byte(w[23:16], gap);
        send_byte(w[31:24], gap);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        byte_valid_i = 1'b0;
        byte_i = 8'h00;
        repeat (3) @(negedge clk_i);
        total++; if ({byte_ready_o, im_we_o, cpu_rst_n_o, done_o, error_o} !== 5'b00000) begin
            bad++; $display("FAIL reset_flags: got %b required 00000",
                            {byte_ready_o, im_we_o, cpu_rst_n_o, done_o, error_o});
        end
        total++; if ({im_addr_o, im_wdata_o, checksum_o} !== 96'd0 || word_count_o !== 6'd0) begin
            bad++; $display("FAIL reset_data: addr=%h wdata=%h ck=%h cnt=%0d required all 0",
                            im_addr_o, im_wdata_o, checksum_o, word_count_o);
        end
        rst_n = 1'b1;
        @(negedge clk_i);
        total++; if (byte_ready_o !== 1'b1) begin
            bad++; $display("FAIL reset_first_ready: got %b required 1", byte_ready_o);
        end
    endtask

    task automatic test_t1_basic();
        do_reset();
        send_word(32'h20010008, 1'b0);
        total++; if (im_we_o !== 1'b1 || im_wdata_o !== 32'h20010008 || im_addr_o !== 32'd0
                     || byte_ready_o !== 1'b0) begin
            bad++; $display("FAIL t1_write_cycle: we=%b data=%h addr=%h rdy=%b required 1 20010008 0 0",
                            im_we_o, im_wdata_o, im_addr_o, byte_ready_o);
        end
        @(negedge clk_i);
        total++; if (byte_ready_o !== 1'b1 || im_we_o !== 1'b0) begin
            bad++; $display("FAIL t1_ready_after_write: rdy=%b we=%b required 1 0", byte_ready_o, im_we_o);
        end
        send_word(32'h00000000, 1'b0);
        total++; if (im_we_o !== 1'b1 || done_o !== 1'b0 || cpu_rst_n_o !== 1'b0) begin
            bad++; $display("FAIL t1_term_write: we=%b done=%b cpurst=%b required 1 0 0",
                            im_we_o, done_o, cpu_rst_n_o);
        end
        byte_valid_i = 1'b0;
        @(negedge clk_i);
        total++; if (done_o !== 1'b1 || cpu_rst_n_o !== 1'b1 || im_we_o !== 1'b0 || im_addr_o !== 32'd4) begin
            bad++; $display("FAIL t1_run: done=%b cpurst=%b we=%b addr=%h required 1 1 0 4",
                            done_o, cpu_rst_n_o, im_we_o, im_addr_o);
        end
        idle(3);
        total++; if (wr_addr.size() !== 2) begin
            bad++; $display("FAIL t1_nwrites: got %0d required 2", wr_addr.size());
        end else begin
            total++; if (wr_addr[0] !== 32'd0 || wr_data[0] !== 32'h20010008
                         || wr_addr[1] !== 32'd4 || wr_data[1] !== 32'd0) begin
                bad++; $display("FAIL t1_writes: %h=%h %h=%h required 0=20010008 4=0",
                                wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
            end
        end
        total++; if (word_count_o !== 6'd2 || error_o !== 1'b0 || checksum_o !== ck(32'h20010008)) begin
            bad++; $display("FAIL t1_status: cnt=%0d err=%b ck=%h required 2 0 %h",
                            word_count_o, error_o, checksum_o, ck(32'h20010008));
        end
    endtask

    task automatic test_t2_toggle();
        logic [31:0] words [4];
        int n_bad_ready;
        words[0] = 32'h11223344; words[1] = 32'hA5A50001;
        words[2] = 32'h000000FF; words[3] = 32'h00000000;
        do_reset();
        for (int i = 0; i < 4; i++) send_word(words[i], 1'b1);
        idle(3);
        total++; if (wr_addr.size() !== 4) begin
            bad++; $display("FAIL t2_nwrites: got %0d required 4", wr_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++; if (wr_addr[i] !== 32'(i * 4) || wr_data[i] !== words[i]) begin
                    bad++; $display("FAIL t2_write%0d: %h=%h required %h=%h",
                                    i, wr_addr[i], wr_data[i], 32'(i * 4), words[i]);
                end
            end
        end
        // Bytes offered in RUN must be ignored.
        n_bad_ready = 0;
        byte_i = 8'h55;
        byte_valid_i = 1'b1;
        repeat (6) begin
            @(negedge clk_i);
            if (byte_ready_o !== 1'b0 || im_we_o !== 1'b0) n_bad_ready++;
        end
        byte_valid_i = 1'b0;
        total++; if (n_bad_ready !== 0) begin
            bad++; $display("FAIL t2_run_ignores: bad cycles=%0d required 0", n_bad_ready);
        end
        total++; if (word_count_o !== 6'd4 || done_o !== 1'b1 || checksum_o !== ck(32'hB6C73444)) begin
            bad++; $display("FAIL t2_status: cnt=%0d done=%b ck=%h required 4 1 %h",
                            word_count_o, done_o, checksum_o, ck(32'hB6C73444));
        end
    endtask

    task automatic test_t3_overflow();
        int n_mis;
        do_reset();
        for (int i = 0; i < 32; i++) send_word(32'h10000000 + 32'(i), 1'b0);
        byte_valid_i = 1'b0;
        @(negedge clk_i);
        total++; if (error_o !== 1'b1 || cpu_rst_n_o !== 1'b0 || done_o !== 1'b0 || byte_ready_o !== 1'b0) begin
            bad++; $display("FAIL t3_err_flags: err=%b cpurst=%b done=%b rdy=%b required 1 0 0 0",
                            error_o, cpu_rst_n_o, done_o, byte_ready_o);
        end
        byte_i = 8'h77;
        byte_valid_i = 1'b1;
        repeat (8) @(negedge clk_i);
        byte_valid_i = 1'b0;
        idle(2);
        total++; if (wr_addr.size() !== 32) begin
            bad++; $display("FAIL t3_nwrites: got %0d required 32", wr_addr.size());
        end else begin
            n_mis = 0;
            for (int i = 0; i < 32; i++)
                if (wr_addr[i] !== 32'(i * 4) || wr_data[i] !== 32'h10000000 + 32'(i)) n_mis++;
            total++; if (n_mis !== 0 || wr_addr[31] !== 32'd124) begin
                bad++; $display("FAIL t3_writes: mismatches=%0d last_addr=%h required 0 7c",
                                n_mis, wr_addr[31]);
            end
        end
        total++; if (word_count_o !== 6'd32 || error_o !== 1'b1 || checksum_o !== ck(32'h000001F0)) begin
            bad++; $display("FAIL t3_status: cnt=%0d err=%b ck=%h required 32 1 %h",
                            word_count_o, error_o, checksum_o, ck(32'h000001F0));
        end
    endtask

    task automatic test_t4_midreset();
        do_reset();
        send_word(32'hDEADBEEF, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        do_reset();
        total++; if (word_count_o !== 6'd0 || checksum_o !== 32'd0 || im_addr_o !== 32'd0) begin
            bad++; $display("FAIL t4_cleared: cnt=%0d ck=%h addr=%h required 0 0 0",
                            word_count_o, checksum_o, im_addr_o);
        end
        send_word(32'hCAFE0013, 1'b0);
        send_word(32'h00000000, 1'b0);
        idle(3);
        total++; if (wr_addr.size() !== 2) begin
            bad++; $display("FAIL t4_nwrites: got %0d required 2", wr_addr.size());
        end else begin
            total++; if (wr_addr[0] !== 32'd0 || wr_data[0] !== 32'hCAFE0013 || wr_addr[1] !== 32'd4) begin
                bad++; $display("FAIL t4_reload: %h=%h next@%h required 0=cafe0013 next@4",
                                wr_addr[0], wr_data[0], wr_addr[1]);
            end
        end
        total++; if (done_o !== 1'b1 || word_count_o !== 6'd2 || checksum_o !== ck(32'hCAFE0013)) begin
            bad++; $display("FAIL t4_status: done=%b cnt=%0d ck=%h required 1 2 %h",
                            done_o, word_count_o, checksum_o, ck(32'hCAFE0013));
        end
    endtask

    task automatic test_t5_term_at_depth();
        do_reset();
        for (int i = 0; i < 31; i++) send_word(32'h10000000 + 32'(i), 1'b0);
        send_word(32'h00000000, 1'b0);
        idle(3);
        total++; if (done_o !== 1'b1 || error_o !== 1'b0 || cpu_rst_n_o !== 1'b1 || word_count_o !== 6'd32) begin
            bad++; $display("FAIL t5_status: done=%b err=%b cpurst=%b cnt=%0d required 1 0 1 32",
                            done_o, error_o, cpu_rst_n_o, word_count_o);
        end
        total++; if (wr_addr.size() !== 32) begin
            bad++; $display("FAIL t5_nwrites: got %0d required 32", wr_addr.size());
        end else begin
            total++; if (wr_addr[31] !== 32'd124 || wr_data[31] !== 32'd0) begin
                bad++; $display("FAIL t5_last: %h=%h required 7c=0", wr_addr[31], wr_data[31]);
            end
        end
        total++; if (checksum_o !== ck(32'hF00001D1)) begin
            bad++; $display("FAIL t5_checksum: got %h required %h", checksum_o, ck(32'hF00001D1));
        end
    endtask

    task automatic test_t6_checksum();
        do_reset();
        send_word(32'h00000001, 1'b0);
        send_word(32'h00000002, 1'b0);
        send_word(32'hFFFFFFFF, 1'b0);
        send_word(32'h00000000, 1'b0);
        idle(3);
        total++; if (checksum_o !== ck(32'd2) || word_count_o !== 6'd4 || done_o !== 1'b1) begin
            bad++; $display("FAIL t6_checksum: ck=%h cnt=%0d done=%b required %h 4 1",
                            checksum_o, word_count_o, done_o, ck(32'd2));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        byte_valid_i = 1'b0;
        byte_i = 8'h00;
        test_reset();
        test_t1_basic();
        test_t2_toggle();
        test_t3_overflow();
        test_t4_midreset();
        test_t5_term_at_depth();
        test_t6_checksum();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
